// File: rtl/pit_pkg.sv
// Shared definitions for the 8254 counter read-back path: RW field codes and
// the byte pointer used by LSB-then-MSB sequencing.
package pit_pkg;

  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_WORD  = 2'b11;

  typedef enum logic {
    PTR_LSB = 1'b0,
    PTR_MSB = 1'b1
  } byte_ptr_t;

endpackage

// File: rtl/pit_hold_reg.sv
// Hold register with a valid flag: captures d only when empty (first load wins)
// and is emptied by clear; clear beats a same-cycle load.
module pit_hold_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Load-if-empty storage; a load while full is dropped so the first capture is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load && !valid) begin
      q     <= d;
      valid <= 1'b1;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/counter_read_latch.sv
// Read-back path of one 8254 counter: counter/status latches and RW-mode byte
// sequencing from the 16-bit counting element onto the 8-bit CPU bus.
module counter_read_latch
  import pit_pkg::*;
#(
  parameter int BYTE_W  = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               rd,
  input  logic               ctrl_wr,
  input  logic [1:0]         ctrl_rw,
  input  logic               status_cmd,
  input  logic [BYTE_W-1:0]  status_in,
  input  logic [COUNT_W-1:0] count_in,
  output logic [BYTE_W-1:0]  data_out,
  output logic               data_valid,
  output logic               ol_valid,
  output logic               st_valid
);

  logic [1:0]         rw_mode;
  byte_ptr_t          byte_ptr;
  byte_ptr_t          ptr_next;
  logic [COUNT_W-1:0] ol;
  logic [BYTE_W-1:0]  st;
  logic [COUNT_W-1:0] src;
  logic [BYTE_W-1:0]  rd_byte;
  logic               take_hi;
  logic               word_done;
  logic               rd_acc;
  logic               ctrl_acc;
  logic               mode_wr;
  logic               ol_load;
  logic               ol_clear;
  logic               st_load;
  logic               st_clear;

  // A control write in the same cycle as a read wins; the read is dropped.
  assign ctrl_acc = cs & ctrl_wr;
  assign rd_acc   = cs & rd & ~ctrl_wr;
  assign mode_wr  = ctrl_acc & (ctrl_rw != RW_LATCH);
  assign src      = ol_valid ? ol : count_in;

  // Byte selection for a read that is not serving the status latch.
  always_comb begin
    take_hi   = 1'b0;
    word_done = 1'b0;
    case (rw_mode)
      RW_LSB: begin
        take_hi   = 1'b0;
        word_done = 1'b1;
      end
      RW_MSB: begin
        take_hi   = 1'b1;
        word_done = 1'b1;
      end
      RW_WORD: begin
        if (byte_ptr == PTR_MSB) begin
          take_hi   = 1'b1;
          word_done = 1'b1;
        end else begin
          take_hi   = 1'b0;
          word_done = 1'b0;
        end
      end
      default: begin
        take_hi   = 1'b0;
        word_done = 1'b1;
      end
    endcase
    if (st_valid) begin
      rd_byte = st;
    end else if (take_hi) begin
      rd_byte = src[COUNT_W-1:BYTE_W];
    end else begin
      rd_byte = src[BYTE_W-1:0];
    end
  end

  // Latch control: status reads leave the count latch and the pointer alone.
  assign ol_load  = ctrl_acc & (ctrl_rw == RW_LATCH);
  assign ol_clear = mode_wr | (rd_acc & ~st_valid & word_done);
  assign st_load  = cs & status_cmd;
  assign st_clear = mode_wr | (rd_acc & st_valid);

  pit_hold_reg #(.W(COUNT_W)) u_ol (
    .clk   (clk),
    .rst   (rst),
    .load  (ol_load),
    .clear (ol_clear),
    .d     (count_in),
    .q     (ol),
    .valid (ol_valid)
  );

  pit_hold_reg #(.W(BYTE_W)) u_st (
    .clk   (clk),
    .rst   (rst),
    .load  (st_load),
    .clear (st_clear),
    .d     (status_in),
    .q     (st),
    .valid (st_valid)
  );

  // Byte pointer next state.
  always_comb begin
    ptr_next = byte_ptr;
    if (mode_wr) begin
      ptr_next = PTR_LSB;
    end else if (rd_acc && !st_valid && rw_mode == RW_WORD) begin
      ptr_next = (byte_ptr == PTR_LSB) ? PTR_MSB : PTR_LSB;
    end else begin
      ptr_next = byte_ptr;
    end
  end

  // Byte pointer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ptr <= PTR_LSB;
    end else begin
      byte_ptr <= ptr_next;
    end
  end

  // RW mode and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_mode    <= RW_WORD;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (mode_wr) begin
        rw_mode <= ctrl_rw;
      end
      data_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= rd_byte;
      end
    end
  end

endmodule

// File: tb/tb_counter_read_latch.sv
// Self-checking bench for counter_read_latch: directed scenarios plus a random
// run checked against a word-level behavioural model.
module tb_counter_read_latch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        ctrl_wr = 1'b0;
  logic [1:0]  ctrl_rw = 2'b00;
  logic        status_cmd = 1'b0;
  logic [7:0]  status_in = 8'h00;
  logic [15:0] count_in = 16'h0000;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        ol_valid;
  logic        st_valid;

  int total = 0;
  int bad = 0;

  // Behavioural model state.
  logic [1:0]  m_mode;
  bit          m_second;
  logic [15:0] m_ol;
  bit          m_olv;
  logic [7:0]  m_st;
  bit          m_stv;
  logic [7:0]  m_dout;
  bit          m_dv;

  counter_read_latch dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .rd         (rd),
    .ctrl_wr    (ctrl_wr),
    .ctrl_rw    (ctrl_rw),
    .status_cmd (status_cmd),
    .status_in  (status_in),
    .count_in   (count_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .ol_valid   (ol_valid),
    .st_valid   (st_valid)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [15:0] word;
    bit stv_before;
    stv_before = m_stv;
    m_dv = 1'b0;
    if (cs) begin
      if (ctrl_wr) begin
        if (ctrl_rw != 2'b00) begin
          m_mode = ctrl_rw; m_second = 1'b0; m_olv = 1'b0; m_stv = 1'b0;
          stv_before = 1'b1;
        end else if (!m_olv) begin
          m_ol = count_in; m_olv = 1'b1;
        end
      end else if (rd) begin
        m_dv = 1'b1;
        if (m_stv) begin
          m_dout = m_st; m_stv = 1'b0;
        end else begin
          word = m_olv ? m_ol : count_in;
          if (m_mode == 2'b01) begin
            m_dout = word[7:0]; m_olv = 1'b0;
          end else if (m_mode == 2'b10) begin
            m_dout = word[15:8]; m_olv = 1'b0;
          end else if (!m_second) begin
            m_dout = word[7:0]; m_second = 1'b1;
          end else begin
            m_dout = word[15:8]; m_second = 1'b0; m_olv = 1'b0;
          end
        end
      end
      if (status_cmd && !stv_before) begin
        m_st = status_in; m_stv = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit c, input bit r, input bit w, input logic [1:0] rw,
                       input bit s, input logic [7:0] sin, input logic [15:0] cnt);
    cs = c; rd = r; ctrl_wr = w; ctrl_rw = rw; status_cmd = s;
    status_in = sin; count_in = cnt;
    model_step();
    @(posedge clk); #1;
    rd = 1'b0; ctrl_wr = 1'b0; status_cmd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_mode = 2'b11; m_second = 1'b0; m_ol = 16'h0000; m_olv = 1'b0;
    m_st = 8'h00; m_stv = 1'b0; m_dout = 8'h00; m_dv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (data_out !== 8'h00)  begin bad++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
    total++; if (ol_valid !== 1'b0)   begin bad++; $display("FAIL reset_olv got=%b exp=0", ol_valid); end
    total++; if (st_valid !== 1'b0)   begin bad++; $display("FAIL reset_stv got=%b exp=0", st_valid); end
  endtask

  task automatic test_word_read();
    drive(1, 0, 1, 2'b11, 0, 8'h00, 16'h1234);
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h1234);
    total++; if (data_out !== 8'h34 || data_valid !== 1'b1) begin bad++; $display("FAIL word_lsb got=%h/%b exp=34/1", data_out, data_valid); end
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h1234);
    total++; if (data_out !== 8'h12 || data_valid !== 1'b1) begin bad++; $display("FAIL word_msb got=%h/%b exp=12/1", data_out, data_valid); end
    drive(1, 0, 0, 2'b00, 0, 8'h00, 16'h1234);
    total++; if (data_valid !== 1'b0 || data_out !== 8'h12) begin bad++; $display("FAIL word_idle got=%h/%b exp=12/0", data_out, data_valid); end
  endtask

  task automatic test_latch();
    drive(1, 0, 1, 2'b11, 0, 8'h00, 16'hABCD);
    drive(1, 0, 1, 2'b00, 0, 8'h00, 16'hABCD);
    total++; if (ol_valid !== 1'b1) begin bad++; $display("FAIL latch_olv got=%b exp=1", ol_valid); end
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h0001);
    total++; if (data_out !== 8'hCD || ol_valid !== 1'b1) begin bad++; $display("FAIL latch_lsb got=%h/%b exp=cd/1", data_out, ol_valid); end
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h0001);
    total++; if (data_out !== 8'hAB || ol_valid !== 1'b0) begin bad++; $display("FAIL latch_msb got=%h/%b exp=ab/0", data_out, ol_valid); end
  endtask

  task automatic test_first_latch_wins();
    drive(1, 0, 1, 2'b01, 0, 8'h00, 16'h0500);
    drive(1, 0, 1, 2'b00, 0, 8'h00, 16'h0500);
    drive(1, 0, 1, 2'b00, 0, 8'h00, 16'h0400);
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h0400);
    total++; if (data_out !== 8'h00 || ol_valid !== 1'b0) begin bad++; $display("FAIL first_latch got=%h/%b exp=00/0", data_out, ol_valid); end
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h1277);
    total++; if (data_out !== 8'h77) begin bad++; $display("FAIL live_lsb got=%h exp=77", data_out); end
  endtask

  task automatic test_status();
    drive(1, 0, 1, 2'b11, 0, 8'h00, 16'h2211);
    drive(1, 0, 0, 2'b00, 1, 8'h86, 16'h2211);
    drive(1, 0, 1, 2'b00, 0, 8'h00, 16'h2211);
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h9999);
    total++; if (data_out !== 8'h86 || st_valid !== 1'b0) begin bad++; $display("FAIL status_rd got=%h/%b exp=86/0", data_out, st_valid); end
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h9999);
    total++; if (data_out !== 8'h11) begin bad++; $display("FAIL status_lsb got=%h exp=11", data_out); end
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h9999);
    total++; if (data_out !== 8'h22) begin bad++; $display("FAIL status_msb got=%h exp=22", data_out); end
    // rd consuming the status in the same cycle as a new status_cmd
    drive(1, 0, 0, 2'b00, 1, 8'h55, 16'h0000);
    drive(1, 1, 0, 2'b00, 1, 8'h66, 16'h0000);
    total++; if (data_out !== 8'h55 || st_valid !== 1'b0) begin bad++; $display("FAIL status_collide got=%h/%b exp=55/0", data_out, st_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 1, 2'b11, 0, 8'h00, 16'hBEEF);
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'hBEEF);
    drive(1, 0, 1, 2'b11, 0, 8'h00, 16'hBEEF);
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'hC0DE);
    total++; if (data_out !== 8'hDE) begin bad++; $display("FAIL ptr_restart got=%h exp=de", data_out); end
    drive(1, 1, 1, 2'b11, 0, 8'h00, 16'h7777);
    total++; if (data_valid !== 1'b0 || data_out !== 8'hDE) begin bad++; $display("FAIL ctrl_rd got=%h/%b exp=de/0", data_out, data_valid); end
  endtask

  task automatic test_cs_and_reset();
    drive(1, 0, 1, 2'b00, 0, 8'h00, 16'h9876);
    drive(0, 1, 1, 2'b01, 1, 8'hAA, 16'h1111);
    total++; if (data_valid !== 1'b0 || ol_valid !== 1'b1 || st_valid !== 1'b0) begin bad++; $display("FAIL cs_low got=%b/%b/%b exp=0/1/0", data_valid, ol_valid, st_valid); end
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h1111);
    total++; if (data_out !== 8'h76) begin bad++; $display("FAIL cs_low_mode got=%h exp=76", data_out); end
    do_reset();
    total++; if (data_out !== 8'h00 || ol_valid !== 1'b0) begin bad++; $display("FAIL mid_reset got=%h/%b exp=00/0", data_out, ol_valid); end
    drive(1, 1, 0, 2'b00, 0, 8'h00, 16'h4321);
    total++; if (data_out !== 8'h21) begin bad++; $display("FAIL reset_ptr got=%h exp=21", data_out); end
  endtask

  task automatic test_random();
    bit c, r, w, s;
    logic [1:0] rw;
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(9) != 0);
      w  = ($urandom_range(5) == 0);
      r  = ($urandom_range(1) == 1);
      s  = !w && ($urandom_range(6) == 0);
      rw = 2'($urandom_range(3));
      drive(c, r, w, rw, s, 8'($urandom), 16'($urandom));
      total++;
      if (data_valid !== m_dv || data_out !== m_dout || ol_valid !== m_olv || st_valid !== m_stv) begin
        bad++;
        $display("FAIL rand[%0d] got=%h/%b/%b/%b exp=%h/%b/%b/%b", i, data_out, data_valid,
                 ol_valid, st_valid, m_dout, m_dv, m_olv, m_stv);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_word_read();
    test_latch();
    test_first_latch_wins();
    test_status();
    test_back_to_back();
    test_cs_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
